// File: rtl/store_narrow_pack.sv
// store_narrow_pack: narrows a register value to the access size and lane-aligns it into 8-byte memory beats,
// splitting boundary-crossing stores into two beats and flagging whether the truncation was lossless.
module store_narrow_pack #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_size,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [7:0]            out_be,
    output logic                  out_last,
    output logic                  out_fit
);
    typedef enum logic [1:0] {EMPTY, ONE, FIRST} state_t;
    state_t state, next;
    logic [7:0] m, res_be;
    logic [DATA_WIDTH-1:0] t, ext, res_data;
    logic [2*DATA_WIDTH-1:0] wide;
    logic [15:0] wide_be;
    logic s, split, accept, fit;
    assign in_ready = !reset && (state == EMPTY || (state == ONE && out_ready));
    assign out_valid = state != EMPTY;
    assign accept = in_valid && in_ready;
    always_comb begin
        s = in_signed;
        m = in_size == 2'd0 ? 8'h01 : in_size == 2'd1 ? 8'h03 : in_size == 2'd2 ? 8'h0F : 8'hFF;
        t = in_size == 2'd0 ? {56'b0, in_data[7:0]} :
            in_size == 2'd1 ? {48'b0, in_data[15:0]} :
            in_size == 2'd2 ? {32'b0, in_data[31:0]} : in_data;
        ext = in_size == 2'd0 ? {{56{s & in_data[7]}}, in_data[7:0]} :
              in_size == 2'd1 ? {{48{s & in_data[15]}}, in_data[15:0]} :
              in_size == 2'd2 ? {{32{s & in_data[31]}}, in_data[31:0]} : in_data;
        fit = ext == in_data;
        // The upper half of the double-width shift is exactly the spill-over into the next word
        wide = {64'b0, t} << {in_addr[2:0], 3'b000};
        wide_be = {8'b0, m} << in_addr[2:0];
        split = |wide_be[15:8];
        next = state;
        if (accept)
            next = split ? FIRST : ONE;
        else if (out_ready && state != EMPTY)
            next = state == FIRST ? ONE : EMPTY;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            out_addr <= '0;
            out_data <= '0;
            out_be   <= '0;
            out_last <= 1'b0;
            out_fit  <= 1'b0;
            res_data <= '0;
            res_be   <= '0;
        end else begin
            state <= next;
            if (accept) begin
                out_addr <= {in_addr[ADDR_WIDTH-1:3], 3'b000};
                out_data <= wide[63:0];
                out_be   <= wide_be[7:0];
                out_last <= !split;
                out_fit  <= fit;
                res_data <= wide[127:64];
                res_be   <= wide_be[15:8];
            end else if (state == FIRST && out_ready) begin
                out_addr <= out_addr + ADDR_WIDTH'(8);
                out_data <= res_data;
                out_be   <= res_be;
                out_last <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_store_narrow_pack.sv
// tb_store_narrow_pack: scoreboard bench; a per-byte address model predicts every beat, tasks add directed checks.
module tb_store_narrow_pack;
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic        last;
        logic        fit;
    } beat_t;
    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, in_ready, in_signed = 1'b0;
    logic [63:0] in_addr = '0, in_data = '0;
    logic [1:0] in_size = '0;
    logic out_valid, out_ready = 1'b1, out_last, out_fit;
    logic [63:0] out_addr, out_data;
    logic [7:0] out_be;
    beat_t q[$];
    beat_t e;
    int errors = 0, checks = 0, beats = 0, cyc = 0;
    bit rnd = 0;
    store_narrow_pack #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_size(in_size), .in_signed(in_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
        .out_last(out_last), .out_fit(out_fit)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            beats++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected beat addr=%h data=%h be=%h", out_addr, out_data, out_be);
            end else begin
                e = q.pop_front();
                if ({out_addr, out_data, out_be, out_last, out_fit} !== {e.addr, e.data, e.be, e.last, e.fit}) begin
                    errors++;
                    $display("FAIL sb_beat got addr=%h data=%h be=%h last=%b fit=%b exp addr=%h data=%h be=%h last=%b fit=%b",
                             out_addr, out_data, out_be, out_last, out_fit, e.addr, e.data, e.be, e.last, e.fit);
                end
            end
        end
    end
    // Call just after a rising edge; returns just after the edge that accepted the request
    task automatic send(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz, input logic sg);
        logic [7:0] be0 = '0, be1 = '0;
        logic [63:0] d0 = '0, d1 = '0, tmp, ext;
        int n = 1 << sz, sh, p;
        logic ok, fit;
        for (int i = 0; i < n; i++) begin
            p = int'(a[2:0]) + i;
            if (p < 8) begin be0[p] = 1'b1; d0[8*p +: 8] = d[8*i +: 8]; end
            else begin be1[p-8] = 1'b1; d1[8*(p-8) +: 8] = d[8*i +: 8]; end
        end
        sh = 64 - 8 * n;
        tmp = d << sh;
        ext = sg ? 64'($signed(tmp) >>> sh) : tmp >> sh;
        fit = ext == d;
        q.push_back('{{a[63:3], 3'b000}, d0, be0, be1 == 0, fit});
        if (be1 != 0) q.push_back('{{a[63:3], 3'b000} + 64'd8, d1, be1, 1'b1, fit});
        in_addr = a; in_data = d; in_size = sz; in_signed = sg; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b0;
    endtask
    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, in_ready, out_addr, out_data, out_be, out_last, out_fit} !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b ready=%b addr=%h data=%h be=%h last=%b fit=%b required all 0",
                     out_valid, in_ready, out_addr, out_data, out_be, out_last, out_fit);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic test_byte();
        send(64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({out_valid, out_addr, out_data, out_be, out_last, out_fit} !== {1'b1, 64'h1000, 64'h8000_0000, 8'h08, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL byte_signed got v=%b addr=%h data=%h be=%h last=%b fit=%b required 1 1000 80000000 08 1 1",
                     out_valid, out_addr, out_data, out_be, out_last, out_fit);
        end
        @(posedge clk);
        #1;
        send(64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid, out_fit} !== 2'b10) begin
            errors++;
            $display("FAIL byte_unsigned_fit got v=%b fit=%b required v=1 fit=0", out_valid, out_fit);
        end
        drain();
    endtask
    task automatic test_split_dword();
        send(64'h2005, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_addr, out_data, out_be, out_last} !== {64'h2000, 64'h6677_8800_0000_0000, 8'hE0, 1'b0}) begin
            errors++;
            $display("FAIL dword_beat0 got addr=%h data=%h be=%h last=%b", out_addr, out_data, out_be, out_last);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_addr, out_data, out_be, out_last, out_fit} !== {1'b1, 64'h2008, 64'h0000_0011_2233_4455, 8'h1F, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL dword_beat1 got v=%b addr=%h data=%h be=%h last=%b fit=%b",
                     out_valid, out_addr, out_data, out_be, out_last, out_fit);
        end
        drain();
    endtask
    task automatic test_split_half();
        send(64'h3007, 64'hBEEF, 2'd1, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_addr, out_data, out_be, out_last} !== {64'h3000, 64'hEF00_0000_0000_0000, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL half_beat0 got addr=%h data=%h be=%h last=%b", out_addr, out_data, out_be, out_last);
        end
        @(negedge clk);
        checks++;
        if ({out_addr, out_data, out_be, out_last} !== {64'h3008, 64'h00BE, 8'h01, 1'b1}) begin
            errors++;
            $display("FAIL half_beat1 got addr=%h data=%h be=%h last=%b", out_addr, out_data, out_be, out_last);
        end
        drain();
    endtask
    task automatic test_back_to_back();
        int t0, b0;
        out_ready = 1'b0;
        send(64'h4004, 64'hDEAD_BEEF, 2'd2, 1'b0);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, out_addr, out_data, out_be, out_last} !== {2'b10, 64'h4000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold got v=%b in_ready=%b addr=%h data=%h be=%h last=%b",
                         out_valid, in_ready, out_addr, out_data, out_be, out_last);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        t0 = cyc;
        b0 = beats;
        for (int i = 0; i < 4; i++) send(64'h5000 + 64'(4 * i), 64'(32'hA000_0000 + i), 2'd2, 1'b0);
        checks++;
        if (cyc - t0 !== 4) begin
            errors++;
            $display("FAIL b2b_cycles got %0d required 4", cyc - t0);
        end
        drain();
        checks++;
        if (beats - b0 !== 5) begin
            errors++;
            $display("FAIL b2b_beats got %0d required 5", beats - b0);
        end
    endtask
    task automatic test_reset_mid_split();
        out_ready = 1'b0;
        send(64'h2005, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid, out_be, out_last} !== {1'b1, 8'hE0, 1'b0}) begin
            errors++;
            $display("FAIL midsplit_beat0 got v=%b be=%h last=%b", out_valid, out_be, out_last);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL midsplit_reset got v=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        q.delete();
        @(negedge clk) reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midsplit_no_beat1 out_valid=%b required 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        send(64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({out_valid, out_addr, out_data, out_be, out_last, out_fit} !== {1'b1, 64'h1000, 64'h8000_0000, 8'h08, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL after_reset got v=%b addr=%h data=%h be=%h last=%b fit=%b",
                     out_valid, out_addr, out_data, out_be, out_last, out_fit);
        end
        drain();
    endtask
    task automatic test_wrap();
        send(64'hFFFF_FFFF_FFFF_FFFA, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_addr, out_be, out_last} !== {64'hFFFF_FFFF_FFFF_FFF8, 8'hFC, 1'b0}) begin
            errors++;
            $display("FAIL wrap_fa_beat0 got addr=%h be=%h last=%b", out_addr, out_be, out_last);
        end
        @(negedge clk);
        checks++;
        if ({out_addr, out_be, out_last} !== {64'h0, 8'h03, 1'b1}) begin
            errors++;
            $display("FAIL wrap_fa_beat1 got addr=%h be=%h last=%b", out_addr, out_be, out_last);
        end
        drain();
        send(64'hFFFF_FFFF_FFFF_FFFE, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_addr, out_be} !== {64'hFFFF_FFFF_FFFF_FFF8, 8'hC0}) begin
            errors++;
            $display("FAIL wrap_fe_beat0 got addr=%h be=%h", out_addr, out_be);
        end
        @(negedge clk);
        checks++;
        if ({out_addr, out_be, out_last} !== {64'h0, 8'h3F, 1'b1}) begin
            errors++;
            $display("FAIL wrap_fe_beat1 got addr=%h be=%h last=%b", out_addr, out_be, out_last);
        end
        drain();
    endtask
    task automatic test_random();
        logic [63:0] d;
        rnd = 1;
        for (int i = 0; i < 60; i++) begin
            d = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) d = d >> $urandom_range(0, 63);
            send({$urandom, $urandom}, d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        rnd = 0;
        drain();
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL random_drain pending=%0d required 0", q.size());
        end
    endtask
    initial begin
        test_reset();
        test_byte();
        test_split_dword();
        test_split_half();
        test_back_to_back();
        test_reset_mid_split();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
